uart_cmd_decoder: RTL

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_decoder_if.sv | 34 +++
 rtl/uart_cmd_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder_if.sv
// Host-side bus of the UART command decoder: byte stream in/out, register
// strobes toward the design under control, and memory port A.
interface uart_cmd_decoder_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] in_data;
  logic        in_valid_pulse;
  logic [31:0] select;
  logic        select_valid_pulse;
  logic [31:0] result;
  logic [8:0]  remote_mem_addr;
  logic [31:0] remote_mem_wdata;
  logic        remote_mem_wr;
  logic [31:0] remote_mem_rdata;
  logic        busy;
  logic [7:0]  err_cnt;

  // Decoder side
  modport master (
    input  rx_data, rx_valid, tx_ready, result, remote_mem_rdata,
    output tx_data, tx_valid, in_data, in_valid_pulse, select, select_valid_pulse,
           remote_mem_addr, remote_mem_wdata, remote_mem_wr, busy, err_cnt
  );

  // Environment side (UART, register file, memory)
  modport slave (
    output rx_data, rx_valid, tx_ready, result, remote_mem_rdata,
    input  tx_data, tx_valid, in_data, in_valid_pulse, select, select_valid_pulse,
           remote_mem_addr, remote_mem_wdata, remote_mem_wr, busy, err_cnt
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Decodes CMD/ADDR/DATA byte frames from a UART into register writes,
// register reads, and memory reads/writes; read data returns MSB first.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_cmd_decoder_if.master  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [7:0] CMD_WR_REG = 8'h57;
  localparam logic [7:0] CMD_RD_REG = 8'h52;
  localparam logic [7:0] CMD_WR_MEM = 8'h4D;
  localparam logic [7:0] CMD_RD_MEM = 8'h6D;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_EXEC, S_MEM_WAIT, S_RESP
  } state_t;

  state_t        state, state_next;
  logic [7:0]    cmd;
  logic [15:0]   addr;
  logic [31:0]   data;
  logic [31:0]   resp;
  logic [1:0]    cnt;
  logic [TW-1:0] timer;

  logic        err_c;
  logic        cmd_known_c;
  logic        is_write_c;
  logic        timer_exp_c;
  logic        tx_fire_c;
  logic [31:0] data_shift_c;
  logic [31:0] rd_word_c;

  assign cmd_known_c  = (bus.rx_data == CMD_WR_REG) || (bus.rx_data == CMD_RD_REG) ||
                        (bus.rx_data == CMD_WR_MEM) || (bus.rx_data == CMD_RD_MEM);
  assign is_write_c   = (cmd == CMD_WR_REG) || (cmd == CMD_WR_MEM);
  assign timer_exp_c  = (timer == TW'(TIMEOUT_CYCLES));
  assign tx_fire_c    = bus.tx_valid && bus.tx_ready;
  assign data_shift_c = {data[23:0], bus.rx_data};
  assign rd_word_c    = (addr == 16'd0) ? bus.result : 32'h0;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next state and protocol-error detection
  always_comb begin
    state_next = state;
    err_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.rx_valid) begin
          if (cmd_known_c) state_next = S_ADDR;
          else             err_c      = 1'b1;
        end
      end
      S_ADDR: begin
        if (bus.rx_valid) begin
          if (cnt == 2'd1) state_next = is_write_c ? S_DATA : S_EXEC;
        end else if (timer_exp_c) begin
          state_next = S_IDLE;
          err_c      = 1'b1;
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          if (cnt == 2'd3) state_next = S_EXEC;
        end else if (timer_exp_c) begin
          state_next = S_IDLE;
          err_c      = 1'b1;
        end
      end
      S_EXEC: begin
        err_c = bus.rx_valid;
        if (is_write_c) begin
          state_next = S_IDLE;
          if ((cmd == CMD_WR_REG) && (addr > 16'd1)) err_c = 1'b1;
        end else if (cmd == CMD_RD_MEM) begin
          state_next = S_MEM_WAIT;
        end else begin
          state_next = S_RESP;
        end
      end
      S_MEM_WAIT: begin
        err_c      = bus.rx_valid;
        state_next = S_RESP;
      end
      S_RESP: begin
        err_c = bus.rx_valid;
        if (tx_fire_c && (cnt == 2'd3)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Frame capture, strobes, response shifter and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd                    <= '0;
      addr                   <= '0;
      data                   <= '0;
      resp                   <= '0;
      cnt                    <= '0;
      timer                  <= '0;
      bus.tx_data            <= '0;
      bus.tx_valid           <= 1'b0;
      bus.in_data            <= '0;
      bus.in_valid_pulse     <= 1'b0;
      bus.select             <= '0;
      bus.select_valid_pulse <= 1'b0;
      bus.remote_mem_addr    <= '0;
      bus.remote_mem_wdata   <= '0;
      bus.remote_mem_wr      <= 1'b0;
      bus.busy               <= 1'b0;
      bus.err_cnt            <= '0;
    end else begin
      bus.in_valid_pulse     <= 1'b0;
      bus.select_valid_pulse <= 1'b0;
      bus.remote_mem_wr      <= 1'b0;
      bus.busy               <= (state_next != S_IDLE);
      if (err_c && (bus.err_cnt != 8'hFF)) bus.err_cnt <= bus.err_cnt + 8'd1;

      case (state)
        S_IDLE: begin
          if (bus.rx_valid && cmd_known_c) begin
            cmd   <= bus.rx_data;
            cnt   <= '0;
            timer <= '0;
          end
        end
        S_ADDR, S_DATA: begin
          if (bus.rx_valid) begin
            timer <= '0;
            cnt   <= cnt + 2'd1;
            if (state == S_ADDR) begin
              addr <= {addr[7:0], bus.rx_data};
              if (cnt == 2'd1) begin
                cnt <= '0;
                // Memory read address must be on the port during EXEC
                if (cmd == CMD_RD_MEM) bus.remote_mem_addr <= {addr[0], bus.rx_data};
              end
            end else begin
              data <= data_shift_c;
              if (cnt == 2'd3) begin
                if (cmd == CMD_WR_REG) begin
                  if (addr == 16'd0) begin
                    bus.in_data        <= data_shift_c;
                    bus.in_valid_pulse <= 1'b1;
                  end else if (addr == 16'd1) begin
                    bus.select             <= data_shift_c;
                    bus.select_valid_pulse <= 1'b1;
                  end
                end else begin
                  bus.remote_mem_addr  <= addr[8:0];
                  bus.remote_mem_wdata <= data_shift_c;
                  bus.remote_mem_wr    <= 1'b1;
                end
              end
            end
          end else if (!timer_exp_c) begin
            timer <= timer + TW'(1);
          end
        end
        S_EXEC: begin
          if (cmd == CMD_RD_REG) begin
            resp         <= rd_word_c;
            bus.tx_data  <= rd_word_c[31:24];
            bus.tx_valid <= 1'b1;
            cnt          <= '0;
          end
        end
        S_MEM_WAIT: begin
          resp         <= bus.remote_mem_rdata;
          bus.tx_data  <= bus.remote_mem_rdata[31:24];
          bus.tx_valid <= 1'b1;
          cnt          <= '0;
        end
        S_RESP: begin
          if (tx_fire_c) begin
            cnt         <= cnt + 2'd1;
            resp        <= {resp[23:0], 8'h00};
            bus.tx_data <= resp[23:16];
            if (cnt == 2'd3) bus.tx_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
